// File: rtl/pipelined_proc_hier.sv
// pipelined_proc_hier: 16-bit five-stage in-order pipeline (IF, ID, EX, MEM, WB) with
// interlocked RAW hazards, predict-not-taken branches, a sticky halt and debug taps.
module pipelined_proc_hier #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_WORDS = 256,
    parameter logic [15:0] IMEM_INIT [IMEM_WORDS] = '{default: 16'h0800}
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc,
    output logic [15:0] inst,
    output logic        reg_write,
    output logic [2:0]  write_register,
    output logic [15:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data_in,
    output logic [15:0] mem_data_out,
    output logic        halt,
    output logic [31:0] cycle_count
);
    localparam int unsigned XW    = 16;
    localparam int unsigned CW    = 32;
    localparam int unsigned NREGS = 8;
    localparam int unsigned IAW   = $clog2(IMEM_WORDS);
    localparam int unsigned DAW   = $clog2(DMEM_WORDS);

    localparam logic [XW-1:0] NOP_INST = 16'h0800;
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_RTYPE = 5'b11011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;

    typedef struct packed {
        logic          valid;
        logic [XW-1:0] inst;
        logic [XW-1:0] pc_next;
    } ifid_t;

    typedef struct packed {
        logic          halt;
        logic          reg_wr;
        logic          mem_rd;
        logic          mem_wr;
        logic          beqz;
        logic          bnez;
        logic          rtype;
        logic [1:0]    func;
        logic [2:0]    dest;
        logic [XW-1:0] a;
        logic [XW-1:0] b;
        logic [XW-1:0] imm;
        logic [XW-1:0] pc_next;
    } idex_t;

    typedef struct packed {
        logic          halt;
        logic          reg_wr;
        logic          mem_rd;
        logic          mem_wr;
        logic [2:0]    dest;
        logic [XW-1:0] alu;
        logic [XW-1:0] st_data;
    } exmem_t;

    typedef struct packed {
        logic          reg_wr;
        logic [2:0]    dest;
        logic [XW-1:0] data;
    } memwb_t;

    localparam ifid_t  IFID_BUBBLE  = '{valid: 1'b0, inst: NOP_INST, pc_next: 16'h0000};
    localparam idex_t  IDEX_BUBBLE  = '0;
    localparam exmem_t EXMEM_BUBBLE = '0;
    localparam memwb_t MEMWB_BUBBLE = '0;

    logic [XW-1:0] pc_q, pc_d;
    ifid_t         ifid_q, ifid_d;
    idex_t         idex_q, idex_d;
    exmem_t        exmem_q, exmem_d;
    memwb_t        memwb_q, memwb_d;
    logic          halt_q, halt_d;
    logic          halt_pend_q, halt_pend_d;
    logic [CW-1:0] cycle_q, cycle_d;
    logic [XW-1:0] rf_q [NREGS];
    logic [XW-1:0] dmem_q [DMEM_WORDS];

    logic [4:0]    id_op;
    logic [2:0]    id_rs, id_rt;
    logic [XW-1:0] id_rs_val, id_rt_val;
    logic          id_use_rs, id_use_rt, id_halt, id_stall;
    logic          id_hit_rs, id_hit_rt;
    idex_t         id_ctl;

    logic [XW-1:0] ex_alu, ex_target;
    logic          ex_take;
    logic [XW-1:0] dmem_rdata;

    // ID: decode, register read with same-cycle WB bypass, interlock detection
    always_comb begin
        id_op     = ifid_q.inst[15:11];
        id_rs     = ifid_q.inst[10:8];
        id_rt     = ifid_q.inst[7:5];
        id_rs_val = (memwb_q.reg_wr && memwb_q.dest == id_rs) ? memwb_q.data : rf_q[id_rs];
        id_rt_val = (memwb_q.reg_wr && memwb_q.dest == id_rt) ? memwb_q.data : rf_q[id_rt];
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        id_halt   = 1'b0;
        id_ctl    = IDEX_BUBBLE;
        if (ifid_q.valid) begin
            id_ctl.pc_next = ifid_q.pc_next;
            case (id_op)
                OP_HALT: begin
                    id_halt     = 1'b1;
                    id_ctl.halt = 1'b1;
                end
                OP_ADDI, OP_LD: begin
                    id_use_rs     = 1'b1;
                    id_ctl.reg_wr = 1'b1;
                    id_ctl.mem_rd = (id_op == OP_LD);
                    id_ctl.dest   = id_rt;
                    id_ctl.imm    = {{11{ifid_q.inst[4]}}, ifid_q.inst[4:0]};
                end
                OP_ST: begin
                    id_use_rs     = 1'b1;
                    id_use_rt     = 1'b1;
                    id_ctl.mem_wr = 1'b1;
                    id_ctl.imm    = {{11{ifid_q.inst[4]}}, ifid_q.inst[4:0]};
                end
                OP_RTYPE: begin
                    id_use_rs     = 1'b1;
                    id_use_rt     = 1'b1;
                    id_ctl.reg_wr = 1'b1;
                    id_ctl.rtype  = 1'b1;
                    id_ctl.func   = ifid_q.inst[1:0];
                    id_ctl.dest   = ifid_q.inst[4:2];
                end
                OP_BEQZ, OP_BNEZ: begin
                    id_use_rs   = 1'b1;
                    id_ctl.beqz = (id_op == OP_BEQZ);
                    id_ctl.bnez = (id_op == OP_BNEZ);
                    id_ctl.imm  = {{7{ifid_q.inst[7]}}, ifid_q.inst[7:0], 1'b0};
                end
                default: ;
            endcase
        end
        id_ctl.a  = id_use_rs ? id_rs_val : '0;
        id_ctl.b  = id_use_rt ? id_rt_val : '0;
        id_hit_rs = (idex_q.reg_wr && idex_q.dest == id_rs) || (exmem_q.reg_wr && exmem_q.dest == id_rs);
        id_hit_rt = (idex_q.reg_wr && idex_q.dest == id_rt) || (exmem_q.reg_wr && exmem_q.dest == id_rt);
        id_stall  = (id_use_rs && id_hit_rs) || (id_use_rt && id_hit_rt);
    end

    // EX: ALU, branch resolution
    always_comb begin
        ex_alu = idex_q.a + idex_q.imm;
        if (idex_q.rtype) begin
            case (idex_q.func)
                2'b00:   ex_alu = idex_q.a + idex_q.b;
                2'b01:   ex_alu = idex_q.a - idex_q.b;
                2'b10:   ex_alu = idex_q.a ^ idex_q.b;
                default: ex_alu = idex_q.a & ~idex_q.b;
            endcase
        end
        ex_take   = (idex_q.beqz && idex_q.a == '0) || (idex_q.bnez && idex_q.a != '0);
        ex_target = idex_q.pc_next + idex_q.imm;

        exmem_d         = EXMEM_BUBBLE;
        exmem_d.halt    = idex_q.halt;
        exmem_d.reg_wr  = idex_q.reg_wr;
        exmem_d.mem_rd  = idex_q.mem_rd;
        exmem_d.mem_wr  = idex_q.mem_wr;
        exmem_d.dest    = idex_q.dest;
        exmem_d.alu     = ex_alu;
        exmem_d.st_data = idex_q.mem_wr ? idex_q.b : '0;
    end

    assign dmem_rdata = dmem_q[exmem_q.alu[DAW:1]];

    // MEM: select load data or ALU result for writeback
    always_comb begin
        memwb_d        = MEMWB_BUBBLE;
        memwb_d.reg_wr = exmem_q.reg_wr;
        memwb_d.dest   = exmem_q.dest;
        if (exmem_q.reg_wr) begin
            memwb_d.data = exmem_q.mem_rd ? dmem_rdata : exmem_q.alu;
        end
    end

    // Front-end steering: branch flush beats stall, stall beats halt freeze
    always_comb begin
        pc_d        = pc_q + XW'(2);
        ifid_d      = '{valid: 1'b1, inst: IMEM_INIT[pc_q[IAW:1]], pc_next: pc_q + XW'(2)};
        idex_d      = id_ctl;
        halt_pend_d = halt_pend_q | id_halt;
        halt_d      = halt_q | idex_q.halt;
        cycle_d     = cycle_q + CW'(1);
        if (ex_take) begin
            pc_d        = ex_target;
            ifid_d      = IFID_BUBBLE;
            idex_d      = IDEX_BUBBLE;
            halt_pend_d = halt_pend_q;
        end else if (id_stall) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
            idex_d = IDEX_BUBBLE;
        end else if (id_halt || halt_pend_q) begin
            pc_d   = pc_q;
            ifid_d = IFID_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= '0;
            ifid_q      <= IFID_BUBBLE;
            idex_q      <= IDEX_BUBBLE;
            exmem_q     <= EXMEM_BUBBLE;
            memwb_q     <= MEMWB_BUBBLE;
            halt_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            cycle_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            ifid_q      <= ifid_d;
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            halt_q      <= halt_d;
            halt_pend_q <= halt_pend_d;
            cycle_q     <= cycle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_q <= '{default: '0};
        end else if (memwb_q.reg_wr) begin
            rf_q[memwb_q.dest] <= memwb_q.data;
        end
    end

    // Data memory keeps its contents across reset; in-flight stores are dropped
    always_ff @(posedge clk) begin
        if (rst && exmem_q.mem_wr) begin
            dmem_q[exmem_q.alu[DAW:1]] <= exmem_q.st_data;
        end
    end

    assign pc             = pc_q;
    assign inst           = ifid_q.inst;
    assign reg_write      = memwb_q.reg_wr;
    assign write_register = memwb_q.dest;
    assign write_data     = memwb_q.data;
    assign mem_read       = exmem_q.mem_rd;
    assign mem_write      = exmem_q.mem_wr;
    assign mem_address    = exmem_q.alu;
    assign mem_data_in    = exmem_q.st_data;
    assign mem_data_out   = exmem_q.mem_rd ? dmem_rdata : '0;
    assign halt           = halt_q;
    assign cycle_count    = cycle_q;

endmodule

// File: tb/tb_pipelined_proc_hier.sv
// tb_pipelined_proc_hier: one directed program covering ALU ops, interlocks, load/store,
// branches, halt and mid-run reset, checked cycle by cycle against hand-derived timing.
module tb_pipelined_proc_hier;

    localparam logic [15:0] PROG [256] = '{
        0:  16'h4025,   // 0x00 ADDI r1,r0,5
        1:  16'hD928,   // 0x02 ADD  r2,r1,r1
        2:  16'hD94D,   // 0x04 SUB  r3,r1,r2
        3:  16'h4027,   // 0x06 ADDI r1,r0,7
        4:  16'h8024,   // 0x08 ST   r1 -> [r0+4]
        5:  16'h8864,   // 0x0A LD   r3 <- [r0+4]
        6:  16'h6002,   // 0x0C BEQZ r0,+2
        7:  16'h4081,   // 0x0E ADDI r4,r0,1 (skipped)
        8:  16'h4082,   // 0x10 ADDI r4,r0,2 (skipped)
        9:  16'h40A1,   // 0x12 ADDI r5,r0,1
        10: 16'h6802,   // 0x14 BNEZ r0,+2 (falls through)
        11: 16'h40C3,   // 0x16 ADDI r6,r0,3
        12: 16'hDEBE,   // 0x18 XOR  r7,r6,r5
        13: 16'hDEAB,   // 0x1A ANDN r2,r6,r5
        14: 16'h0000,   // 0x1C HALT
        15: 16'h4089,   // 0x1E ADDI r4,r0,9 (never executes)
        16: 16'h8026,   // 0x20 ST   r1 -> [r0+6] (never executes)
        default: 16'h0800
    };

    // Every writeback the program makes, keyed by cycle_count value
    localparam int NWB = 9;
    localparam int unsigned WB_CYC [NWB] = '{4, 7, 10, 11, 15, 19, 21, 24, 25};
    localparam logic [2:0]  WB_REG [NWB] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd3, 3'd5, 3'd6, 3'd7, 3'd2};
    localparam logic [15:0] WB_DAT [NWB] = '{16'h0005, 16'h000A, 16'hFFFB, 16'h0007, 16'h0007,
                                             16'h0001, 16'h0003, 16'h0002, 16'h0002};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        reg_write;
    logic [2:0]  write_register;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        halt;
    logic [31:0] cycle_count;

    int total = 0;
    int bad   = 0;

    pipelined_proc_hier #(
        .IMEM_WORDS (256),
        .DMEM_WORDS (256),
        .IMEM_INIT  (PROG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .inst           (inst),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .halt           (halt),
        .cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check($sformatf("%s pc", tag),             32'(pc),             32'h0);
        check($sformatf("%s inst", tag),           32'(inst),           32'h0800);
        check($sformatf("%s reg_write", tag),      32'(reg_write),      32'h0);
        check($sformatf("%s write_register", tag), 32'(write_register), 32'h0);
        check($sformatf("%s write_data", tag),     32'(write_data),     32'h0);
        check($sformatf("%s mem_read", tag),       32'(mem_read),       32'h0);
        check($sformatf("%s mem_write", tag),      32'(mem_write),      32'h0);
        check($sformatf("%s mem_address", tag),    32'(mem_address),    32'h0);
        check($sformatf("%s mem_data_in", tag),    32'(mem_data_in),    32'h0);
        check($sformatf("%s mem_data_out", tag),   32'(mem_data_out),   32'h0);
        check($sformatf("%s halt", tag),           32'(halt),           32'h0);
        check($sformatf("%s cycle_count", tag),    cycle_count,         32'h0);
        for (int r = 0; r < 8; r++) begin
            check($sformatf("%s r%0d", tag, r), 32'(dut.rf_q[r]), 32'h0);
        end
    endtask

    task automatic check_cycle(input string tag, input int unsigned c);
        int idx = -1;
        for (int k = 0; k < NWB; k++) begin
            if (WB_CYC[k] == c) idx = k;
        end
        check($sformatf("%s c%0d cycle_count", tag, c), cycle_count, 32'(c));
        check($sformatf("%s c%0d reg_write", tag, c), 32'(reg_write), 32'(idx >= 0));
        if (idx >= 0) begin
            check($sformatf("%s c%0d write_register", tag, c), 32'(write_register), 32'(WB_REG[idx]));
            check($sformatf("%s c%0d write_data", tag, c), 32'(write_data), 32'(WB_DAT[idx]));
        end
        check($sformatf("%s c%0d mem_write", tag, c), 32'(mem_write), 32'(c == 13));
        check($sformatf("%s c%0d mem_read", tag, c), 32'(mem_read), 32'(c == 14));
        if (c == 13) begin
            check($sformatf("%s c%0d st mem_address", tag, c), 32'(mem_address), 32'h0004);
            check($sformatf("%s c%0d st mem_data_in", tag, c), 32'(mem_data_in), 32'h0007);
        end
        if (c == 14) begin
            check($sformatf("%s c%0d ld mem_address", tag, c), 32'(mem_address), 32'h0004);
            check($sformatf("%s c%0d ld mem_data_out", tag, c), 32'(mem_data_out), 32'h0007);
        end
        check($sformatf("%s c%0d halt", tag, c), 32'(halt), 32'(c >= 25));
        case (c)
            1: begin
                check($sformatf("%s c1 pc", tag), 32'(pc), 32'h0002);
                check($sformatf("%s c1 inst", tag), 32'(inst), 32'h4025);
            end
            3: begin
                check($sformatf("%s c3 stall pc", tag), 32'(pc), 32'h0004);
                check($sformatf("%s c3 stall inst", tag), 32'(inst), 32'hD928);
            end
            15: begin
                check($sformatf("%s c15 branch pc", tag), 32'(pc), 32'h0012);
                check($sformatf("%s c15 flush inst", tag), 32'(inst), 32'h0800);
            end
            16: check($sformatf("%s c16 target inst", tag), 32'(inst), 32'h40A1);
            30, 40: begin
                check($sformatf("%s c%0d halted pc", tag, c), 32'(pc), 32'h001E);
                check($sformatf("%s c%0d halted inst", tag, c), 32'(inst), 32'h0800);
            end
            default: ;
        endcase
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle(tag);
        rst = 1'b1;
    endtask

    task automatic run_cycles(input string tag, input int unsigned n);
        for (int unsigned c = 1; c <= n; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(tag, c);
        end
    endtask

    initial begin
        rst = 1'b0;
        @(posedge clk);
        apply_reset("por");
        run_cycles("run1", 40);
        apply_reset("post_halt");
        run_cycles("run2", 9);
        apply_reset("midrun");
        run_cycles("run3", 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
